// File: rtl/k_rctl_t2.sv
// k_rctl_t2: async FIFO read-side controller (Gray read pointer, empty flag, fill level).
// Define K_RCTL_ALMOST_EMPTY_EN to build the registered almost-empty flag; otherwise it is tied to 0.
module k_rctl_t2 #(
    parameter int addr_size = 4,
    parameter int ae_level  = 2
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rget,
    input  logic [addr_size:0]   rq2_wptr,
    output logic                 rempty,
    output logic [addr_size-1:0] raddr,
    output logic [addr_size:0]   rptr,
    output logic [addr_size:0]   rlevel,
    output logic                 ralmost_empty
);
    logic [addr_size:0] rbin, rbinnext, rgraynext, wbin_s, rlevel_next;
    logic               accepted;

    assign raddr     = rbin[addr_size-1:0];
    assign accepted  = rget & ~rempty;
    assign rbinnext  = rbin + {{addr_size{1'b0}}, accepted};
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;

    always_comb begin
        wbin_s = '0;
        wbin_s[addr_size] = rq2_wptr[addr_size];
        for (int i = addr_size - 1; i >= 0; i--)
            wbin_s[i] = wbin_s[i+1] ^ rq2_wptr[i];
    end

    // Level uses the synchronized (stale) write pointer, so it can only under-report.
    assign rlevel_next = wbin_s - rbinnext;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            rlevel <= '0;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= (rgraynext == rq2_wptr);
            rlevel <= rlevel_next;
        end
    end

`ifdef K_RCTL_ALMOST_EMPTY_EN
    localparam logic [addr_size:0] ae_thr = ae_level[addr_size:0];
    always_ff @(posedge rclk) begin
        if (rrst) ralmost_empty <= 1'b1;
        else      ralmost_empty <= (rlevel_next <= ae_thr);
    end
`else
    assign ralmost_empty = 1'b0;
`endif
endmodule

// File: tb/tb_k_rctl_t2.sv
// tb_k_rctl_t2: directed self-checking bench for k_rctl_t2 (addr_size=4, ae_level=2).
module tb_k_rctl_t2;
    logic       rclk = 1'b0;
    logic       rrst, rget;
    logic [4:0] rq2_wptr;
    logic       rempty, ralmost_empty;
    logic [3:0] raddr;
    logic [4:0] rptr, rlevel, prev_ptr;
    int checks = 0, errors = 0;
    int rb, wb, lvl;
    logic empty_m, acc;

`ifdef K_RCTL_ALMOST_EMPTY_EN
    localparam bit ae_en = 1'b1;
`else
    localparam bit ae_en = 1'b0;
`endif

    k_rctl_t2 #(.addr_size(4), .ae_level(2)) dut (
        .rclk(rclk), .rrst(rrst), .rget(rget), .rq2_wptr(rq2_wptr),
        .rempty(rempty), .raddr(raddr), .rptr(rptr), .rlevel(rlevel),
        .ralmost_empty(ralmost_empty)
    );

    always #5 rclk = ~rclk;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    initial begin
        // Reset with arbitrary inputs
        rrst = 1'b1; rget = 1'b1; rq2_wptr = 5'h7;
        tick; tick;
        check("rst_empty", rempty, 1);
        check("rst_rptr", rptr, 0);
        check("rst_raddr", raddr, 0);
        check("rst_level", rlevel, 0);
        check("rst_ae", ralmost_empty, ae_en);

        // Fill to 5 with reads idle
        rrst = 1'b0; rget = 1'b0; rq2_wptr = 5'h0;
        tick;
        check("idle_empty", rempty, 1);
        for (int k = 1; k <= 5; k++) begin
            rq2_wptr = gray(k);
            tick;
        end
        check("fill_empty", rempty, 0);
        check("fill_level", rlevel, 5);

        // Drain 5 words
        rget = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_raddr", raddr, i);
            tick;
            check("drain_level", rlevel, 4 - i);
            check("drain_ae", ralmost_empty, ae_en && (4 - i) <= 2);
        end
        check("drain_empty", rempty, 1);
        tick;
        check("under_rptr", rptr, gray(5));
        check("under_raddr", raddr, 5);
        check("under_empty", rempty, 1);

        // Simultaneous read and write at level 1
        rget = 1'b0; rq2_wptr = gray(6);
        tick;
        check("sim_pre_level", rlevel, 1);
        rget = 1'b1; rq2_wptr = gray(7);
        tick;
        check("sim_empty", rempty, 0);
        check("sim_level", rlevel, 1);
        check("sim_rptr", rptr, gray(6));

        // Interleaved writes and reads across the 16 and 32 wrap points
        rb = 6; wb = 7; empty_m = 1'b0;
        for (int n = 0; n < 40; n++) begin
            prev_ptr = rptr;
            wb = (wb + 1) % 32;
            rq2_wptr = gray(wb);
            rget = 1'b1;
            acc = !empty_m;
            rb = (rb + int'(acc)) % 32;
            empty_m = (rb == wb);
            lvl = (wb - rb + 32) % 32;
            tick;
            check("wrap_raddr", raddr, rb % 16);
            check("wrap_rptr", rptr, gray(rb));
            check("wrap_empty", rempty, empty_m);
            check("wrap_level", rlevel, lvl);
            check("wrap_hamming", ($countones(rptr ^ prev_ptr) <= 1), 1);
        end

        // Full level after reset
        rrst = 1'b1; rget = 1'b0;
        tick;
        rrst = 1'b0; rq2_wptr = gray(16);
        tick;
        check("full_level", rlevel, 16);
        check("full_empty", rempty, 0);
        check("full_ae", ralmost_empty, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/k_rctl_t2.md
K_RCTL_T2 -- requirements
Module: k_rctl_t2

Interface
REQ-001 Parameter: addr_size, default 4, FIFO address width; depth = 2**addr_size.
REQ-002 Parameter: ae_level, default 2, almost-empty threshold in words (0 .. 2**addr_size).
REQ-003 Ports:
- rclk, input, 1, read-domain clock; all state updates on rising edge.
- rrst, input, 1, synchronous active-high reset.
- rget, input, 1, read request for this cycle.
- rq2_wptr, input, addr_size+1, write pointer (Gray) already synchronized into rclk domain.
- rempty, output, 1, FIFO empty flag (registered).
- raddr, output, addr_size, memory read address (binary).
- rptr, output, addr_size+1, read pointer (Gray, registered), sent to the write-side synchronizer.
- rlevel, output, addr_size+1, read-side fill-level estimate (registered).
- ralmost_empty, output, 1, almost-empty flag (registered).
REQ-004 One clock, rclk; reset rrst is synchronous and active-high; no other clock or reset.

Function
REQ-005 Internal binary read pointer rbin, addr_size+1 bits; raddr = rbin[addr_size-1:0], combinational from the register.
REQ-006 Read accepted = rget & ~rempty; rget while rempty ignored, no pointer change.
REQ-007 rbinnext = rbin + accepted, modulo 2**(addr_size+1); MSB wrap at 2*depth is legal and silent.
REQ-008 rgraynext = (rbinnext >> 1) ^ rbinnext; rbin <= rbinnext, rptr <= rgraynext each cycle.
REQ-009 rempty <= (rgraynext == rq2_wptr); flag is registered, asserted the same edge the last word is read.
REQ-010 rempty deassertion latency: one rclk after rq2_wptr changes (synchronizer latency excluded).
REQ-011 Synced write binary wbin_s = Gray-to-binary of rq2_wptr (bit i = XOR of bits addr_size..i).
REQ-012 rlevel <= (wbin_s - rbinnext) mod 2**(addr_size+1); range 0..depth; pessimistic (never exceeds true level).
REQ-013 Simultaneous read accept and rq2_wptr change in one cycle: both reflected in the next-cycle rempty/rlevel.
REQ-014 rptr changes at most one bit per rclk edge (Gray property), including at wrap-around.

Reset
REQ-015 While rrst is high at a rising rclk: rbin=0, rptr=0, raddr=0, rempty=1, rlevel=0, ralmost_empty=1.
REQ-016 Reset mid-operation discards read state unconditionally; the write side must be reset in the same window. Until then, rempty follows REQ-009 on the first post-reset edge.
REQ-017 No output is X after the first reset edge; rget is ignored during reset.

Configuration
REQ-018 Macro K_RCTL_ALMOST_EMPTY_EN compiles the almost-empty logic.
REQ-019 Defined: ralmost_empty <= (next rlevel <= ae_level); registered, same timing as rlevel.
REQ-020 Undefined: ralmost_empty is tied to constant 0, its register and comparator are absent, and the port remains. rlevel is unaffected.

Verification
REQ-021 Reset check: rrst=1 for 2 cycles, arbitrary rget/rq2_wptr -> rempty=1, rptr=0, raddr=0, rlevel=0, ralmost_empty=1.
REQ-022 Fill then drain: rq2_wptr steps Gray 0->5 (binary 5), rget=0 -> rempty=0 and rlevel=5 one cycle after the last step. Then rget=1 for 5 cycles -> raddr 0..4, rempty=1 on the 5th edge, rget 6th cycle leaves rptr unchanged.
REQ-023 Wrap: with addr_size=4, run 40 writes and 40 reads interleaved -> raddr wraps 15->0, rbin MSB toggles at 16 and 32, rptr Hamming distance <=1 per edge, no spurious rempty.
REQ-024 Simultaneous: level 1, rget=1 and rq2_wptr advances by 1 in the same cycle -> next cycle rempty=0, rlevel=1.
REQ-025 Almost-empty (macro defined, ae_level=2): levels 4,3,2,1 via reads -> ralmost_empty 0,0,1,1. With the macro undefined -> ralmost_empty constant 0 after reset.
REQ-026 Full level: rq2_wptr = Gray of 16, rbin=0 -> rlevel=16, rempty=0.
